// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Merges two register-file write sources onto a single write port.
//   The primary source (writeback stage) has no backpressure and normally
//   wins; the secondary source (multicycle unit) is buffered in a 2-entry
//   in-order FIFO and drained when the primary is idle. A starvation
//   counter forces a FIFO drain (stalling the pipeline) after STARVE_MAX
//   consecutive primary wins. FIFO entries overwritten by a newer primary
//   write to the same register are marked dead and popped silently.
//
// Ports
//   rfa_clk, rfa_rst        clock, asynchronous active-high reset
//   rfa_i_wb_we/addr/data   primary write request (addr 0 = no write)
//   rfa_i_mc_valid/addr/data, rfa_o_mc_ready
//                           secondary valid/ready handshake
//   rfa_o_we/addr/data      registered register-file write port
//   rfa_o_stall             pipeline stall (primary ignored while high)
//   rfa_o_pending           FIFO occupancy, including dead entries

module rf_write_arbiter #(
    parameter int DWIDTH     = 32,
    parameter int AWIDTH     = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic              rfa_clk,
    input  logic              rfa_rst,
    input  logic              rfa_i_wb_we,
    input  logic [AWIDTH-1:0] rfa_i_wb_addr,
    input  logic [DWIDTH-1:0] rfa_i_wb_data,
    input  logic              rfa_i_mc_valid,
    output logic              rfa_o_mc_ready,
    input  logic [AWIDTH-1:0] rfa_i_mc_addr,
    input  logic [DWIDTH-1:0] rfa_i_mc_data,
    output logic              rfa_o_we,
    output logic [AWIDTH-1:0] rfa_o_addr,
    output logic [DWIDTH-1:0] rfa_o_data,
    output logic              rfa_o_stall,
    output logic [1:0]        rfa_o_pending
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [AWIDTH-1:0] fifo_addr [2];
    logic [DWIDTH-1:0] fifo_data [2];
    logic [1:0]        fifo_dead;
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        count;
    logic [3:0]        starve;

    logic fifo_nonempty;
    logic wb_live;
    logic grant_wb;
    logic head_sel;
    logic head_write;
    logic push;

    always_comb begin
        fifo_nonempty  = (count != 2'd0);
        rfa_o_mc_ready = (count < 2'd2);
        rfa_o_stall    = (starve == STARVE_LIM) && fifo_nonempty;
        wb_live        = rfa_i_wb_we && (rfa_i_wb_addr != '0);
        grant_wb       = wb_live && !rfa_o_stall;
        // Head is selected when forced by the stall or when the primary is idle;
        // a dead head is popped but produces no write.
        head_sel       = fifo_nonempty && (rfa_o_stall || !wb_live);
        head_write     = head_sel && !fifo_dead[rd_ptr];
        // Address-0 pushes complete the handshake but are never stored.
        push           = rfa_i_mc_valid && rfa_o_mc_ready && (rfa_i_mc_addr != '0);
    end

    always_ff @(posedge rfa_clk or posedge rfa_rst) begin
        if (rfa_rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_addr[i] <= '0;
                fifo_data[i] <= '0;
            end
            fifo_dead  <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= '0;
            starve     <= '0;
            rfa_o_we   <= 1'b0;
            rfa_o_addr <= '0;
            rfa_o_data <= '0;
        end else begin
            rfa_o_we <= grant_wb || head_write;
            if (grant_wb) begin
                rfa_o_addr <= rfa_i_wb_addr;
                rfa_o_data <= rfa_i_wb_data;
            end else if (head_write) begin
                rfa_o_addr <= fifo_addr[rd_ptr];
                rfa_o_data <= fifo_data[rd_ptr];
            end

            // Kill older entries targeting the register the primary writes now.
            // Unoccupied slots may be flagged too; a push always clears its slot,
            // which also keeps a same-edge push to that address live.
            if (grant_wb) begin
                for (int unsigned i = 0; i < 2; i++) begin
                    if (fifo_addr[i] == rfa_i_wb_addr) begin
                        fifo_dead[i] <= 1'b1;
                    end
                end
            end
            if (push) begin
                fifo_addr[wr_ptr] <= rfa_i_mc_addr;
                fifo_data[wr_ptr] <= rfa_i_mc_data;
                fifo_dead[wr_ptr] <= 1'b0;
                wr_ptr            <= ~wr_ptr;
            end
            if (head_sel) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, head_sel};

            // Dead pops leave the counter untouched.
            if (head_write) begin
                starve <= '0;
            end else if (head_sel) begin
                starve <= starve;
            end else if (grant_wb && fifo_nonempty) begin
                if (starve != STARVE_LIM) begin
                    starve <= starve + 4'd1;
                end
            end else if (!fifo_nonempty) begin
                starve <= '0;
            end
        end
    end

    assign rfa_o_pending = count;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter
//   Directed scoreboard bench for rf_write_arbiter (default parameters).
//   Stimulus pushes each hand-computed write into exp_q; an independent
//   monitor pops and compares whenever rfa_o_we is seen high.

module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        mc_valid;
    logic        mc_ready;
    logic [4:0]  mc_addr;
    logic [31:0] mc_data;
    logic        o_we;
    logic [4:0]  o_addr;
    logic [31:0] o_data;
    logic        o_stall;
    logic [1:0]  o_pending;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q [$];
    int  n_tests = 0;
    int  n_fail  = 0;

    always #5 clk = ~clk;

    rf_write_arbiter #(
        .DWIDTH(32),
        .AWIDTH(5),
        .STARVE_MAX(4)
    ) dut (
        .rfa_clk       (clk),
        .rfa_rst       (rst),
        .rfa_i_wb_we   (wb_we),
        .rfa_i_wb_addr (wb_addr),
        .rfa_i_wb_data (wb_data),
        .rfa_i_mc_valid(mc_valid),
        .rfa_o_mc_ready(mc_ready),
        .rfa_i_mc_addr (mc_addr),
        .rfa_i_mc_data (mc_data),
        .rfa_o_we      (o_we),
        .rfa_o_addr    (o_addr),
        .rfa_o_data    (o_data),
        .rfa_o_stall   (o_stall),
        .rfa_o_pending (o_pending)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic drive_wb(input logic we, input logic [4:0] a, input logic [31:0] d);
        wb_we   = we;
        wb_addr = a;
        wb_data = d;
    endtask

    task automatic drive_mc(input logic v, input logic [4:0] a, input logic [31:0] d);
        mc_valid = v;
        mc_addr  = a;
        mc_data  = d;
    endtask

    // Monitor: every observed write must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && o_we === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr=%0d data=0x%0h, expected no write", o_addr, o_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (o_addr !== e.addr || o_data !== e.data) begin
                    n_fail++;
                    $display("FAIL write_check: got addr=%0d data=0x%0h expected addr=%0d data=0x%0h",
                             o_addr, o_data, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        drive_wb(1'b0, 5'd0, 32'h0);
        drive_mc(1'b0, 5'd0, 32'h0);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we",      32'(o_we), 32'd0);
        chk("rst_addr",    32'(o_addr), 32'd0);
        chk("rst_data",    o_data, 32'd0);
        chk("rst_pending", 32'(o_pending), 32'd0);
        chk("rst_ready",   32'(mc_ready), 32'd1);
        chk("rst_stall",   32'(o_stall), 32'd0);
        @(negedge clk) rst = 1'b0;
        step();

        // Primary only
        drive_wb(1'b1, 5'd10, 32'hDEADBEEF);
        expect_wr(5'd10, 32'hDEADBEEF);
        step();
        chk("prim_we_hi", 32'(o_we), 32'd1);
        drive_wb(1'b0, 5'd0, 32'h0);
        step();
        chk("prim_we_lo", 32'(o_we), 32'd0);

        // Secondary with idle primary
        drive_mc(1'b1, 5'd5, 32'h1234);
        chk("idle_ready_pre", 32'(mc_ready), 32'd1);
        step();
        drive_mc(1'b0, 5'd0, 32'h0);
        chk("idle_pending1", 32'(o_pending), 32'd1);
        chk("idle_ready1",   32'(mc_ready), 32'd1);
        expect_wr(5'd5, 32'h1234);
        step();
        chk("idle_pending0", 32'(o_pending), 32'd0);
        chk("idle_ready2",   32'(mc_ready), 32'd1);
        step();

        // Starvation: four primary wins, then a forced drain of addr 7
        drive_mc(1'b1, 5'd7, 32'h7777);
        step();
        drive_mc(1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("starve_nostall", 32'(o_stall), 32'd0);
            drive_wb(1'b1, 5'(8 + i), 32'h100 + 32'(i));
            expect_wr(5'(8 + i), 32'h100 + 32'(i));
            step();
        end
        chk("starve_stall",   32'(o_stall), 32'd1);
        chk("starve_pending", 32'(o_pending), 32'd1);
        drive_wb(1'b1, 5'd12, 32'h104);
        expect_wr(5'd7, 32'h7777);
        step();
        drive_wb(1'b0, 5'd0, 32'h0);
        chk("starve_released", 32'(o_stall), 32'd0);
        chk("starve_drained",  32'(o_pending), 32'd0);

        // Full FIFO: third request held until a pop
        drive_wb(1'b1, 5'd20, 32'h20);
        drive_mc(1'b1, 5'd9, 32'h900);
        expect_wr(5'd20, 32'h20);
        step();
        drive_wb(1'b1, 5'd21, 32'h21);
        drive_mc(1'b1, 5'd10, 32'hA00);
        expect_wr(5'd21, 32'h21);
        step();
        chk("full_pending", 32'(o_pending), 32'd2);
        chk("full_ready",   32'(mc_ready), 32'd0);
        drive_wb(1'b1, 5'd22, 32'h22);
        drive_mc(1'b1, 5'd11, 32'hB00);
        expect_wr(5'd22, 32'h22);
        step();
        chk("full_held_pending", 32'(o_pending), 32'd2);
        chk("full_held_ready",   32'(mc_ready), 32'd0);
        drive_wb(1'b0, 5'd0, 32'h0);
        expect_wr(5'd9, 32'h900);
        step();
        chk("full_pop_pending", 32'(o_pending), 32'd1);
        chk("full_pop_ready",   32'(mc_ready), 32'd1);
        expect_wr(5'd10, 32'hA00);
        step();
        drive_mc(1'b0, 5'd0, 32'h0);
        chk("full_pushpop_pending", 32'(o_pending), 32'd1);
        expect_wr(5'd11, 32'hB00);
        step();
        chk("full_empty", 32'(o_pending), 32'd0);

        // WAW squash
        drive_mc(1'b1, 5'd3, 32'hAAAA);
        step();
        drive_mc(1'b0, 5'd0, 32'h0);
        drive_wb(1'b1, 5'd3, 32'hBBBB);
        expect_wr(5'd3, 32'hBBBB);
        step();
        chk("waw_pending", 32'(o_pending), 32'd1);
        drive_wb(1'b0, 5'd0, 32'h0);
        step();
        chk("waw_dead_we",  32'(o_we), 32'd0);
        chk("waw_dead_pop", 32'(o_pending), 32'd0);
        step();

        // Same-edge push to the primary's address stays live
        drive_wb(1'b1, 5'd4, 32'h44);
        drive_mc(1'b1, 5'd4, 32'h55);
        expect_wr(5'd4, 32'h44);
        step();
        drive_wb(1'b0, 5'd0, 32'h0);
        drive_mc(1'b0, 5'd0, 32'h0);
        expect_wr(5'd4, 32'h55);
        step();
        chk("same_edge_pending", 32'(o_pending), 32'd0);

        // Address 0 on both sources: nothing written or stored
        drive_wb(1'b1, 5'd0, 32'hF0);
        drive_mc(1'b1, 5'd0, 32'hF1);
        step();
        drive_wb(1'b0, 5'd0, 32'h0);
        drive_mc(1'b0, 5'd0, 32'h0);
        chk("addr0_we",      32'(o_we), 32'd0);
        chk("addr0_pending", 32'(o_pending), 32'd0);

        // Reset with a full FIFO
        drive_wb(1'b1, 5'd15, 32'h15);
        drive_mc(1'b1, 5'd13, 32'hD00);
        expect_wr(5'd15, 32'h15);
        step();
        drive_wb(1'b1, 5'd16, 32'h16);
        drive_mc(1'b1, 5'd14, 32'hE00);
        expect_wr(5'd16, 32'h16);
        step();
        chk("prerst_pending", 32'(o_pending), 32'd2);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_we",      32'(o_we), 32'd0);
        chk("midrst_addr",    32'(o_addr), 32'd0);
        chk("midrst_data",    o_data, 32'd0);
        chk("midrst_pending", 32'(o_pending), 32'd0);
        chk("midrst_ready",   32'(mc_ready), 32'd1);
        chk("midrst_stall",   32'(o_stall), 32'd0);
        drive_wb(1'b0, 5'd0, 32'h0);
        drive_mc(1'b1, 5'd17, 32'h1700);
        step();
        chk("rst_hs_lost", 32'(o_pending), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive_mc(1'b0, 5'd0, 32'h0);
        step();
        step();
        chk("postrst_we",      32'(o_we), 32'd0);
        chk("postrst_pending", 32'(o_pending), 32'd0);
        step();

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
